shift_reg2_driver: RTL

- Command-side initiator for the 8-bit shift register: accepts one transaction per request (load value, direction, shift count) on a valid/ready interface.
- Sequences the register's enable, shift_direction and data_in pins across multiple cycles, then reads back data_out.
- Checks the read-back value against an internal reference model and returns result plus error flag on a valid/ready response channel.

---
 rtl/shift_reg2_driver_if.sv | 30 +++
 rtl/shift_reg2_driver.sv | 125 ++++++++++++
 2 files changed

// File: rtl/shift_reg2_driver_if.sv
// Bundles the request, response and shift-register pins of shift_reg2_driver.
// The master modport is the driver's view of these pins.
interface shift_reg2_driver_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic       req_dir;
    logic [3:0] req_count;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       sr_enable;
    logic [2:0] sr_shift_direction;
    logic [7:0] sr_data_in;
    logic [7:0] sr_data_out;
    logic       busy;

    modport master (
        input  req_valid, req_data, req_dir, req_count, rsp_ready, sr_data_out,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output sr_enable, sr_shift_direction, sr_data_in, busy
    );

    modport slave (
        output req_valid, req_data, req_dir, req_count, rsp_ready, sr_data_out,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  sr_enable, sr_shift_direction, sr_data_in, busy
    );
endinterface

// File: rtl/shift_reg2_driver.sv
// Drives an 8-bit shift register through load/shift/capture for each request and
// compares the read-back value against an internal reference model.
module shift_reg2_driver #(
    parameter logic [2:0]  CODE_LOAD = 3'b011,
    parameter logic [2:0]  CODE_SHR  = 3'b000,
    parameter logic [2:0]  CODE_SHL  = 3'b100,
    parameter int unsigned MAX_CNT   = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    shift_reg2_driver_if.master io_bus
);

    localparam logic [3:0] MaxCnt = 4'(MAX_CNT);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StCapture,
        StResp
    } state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic [7:0] r_data;
    logic       r_dir;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic [7:0] r_model;
    logic [7:0] w_model_next;
    logic [7:0] r_rsp_data;
    logic       r_rsp_err;
    logic       w_accept;
    logic [3:0] w_req_cnt_sat;

    assign w_accept      = io_bus.req_valid && (r_state == StIdle);
    assign w_req_cnt_sat = (io_bus.req_count > MaxCnt) ? MaxCnt : io_bus.req_count;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_model_next = r_model;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StLoad;
                    w_cnt_next   = w_req_cnt_sat;
                    w_model_next = io_bus.req_data;
                end
            end
            StLoad: begin
                w_state_next = (r_cnt != 4'd0) ? StShift : StCapture;
            end
            StShift: begin
                w_cnt_next   = r_cnt - 4'd1;
                w_model_next = r_dir ? {r_model[6:0], 1'b0} : {1'b0, r_model[7:1]};
                if (r_cnt == 4'd1) begin
                    w_state_next = StCapture;
                end
            end
            StCapture: begin
                w_state_next = StResp;
            end
            StResp: begin
                if (io_bus.rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_data     <= 8'h00;
            r_dir      <= 1'b0;
            r_cnt      <= 4'd0;
            r_model    <= 8'h00;
            r_rsp_data <= 8'h00;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_model <= w_model_next;
            if (w_accept) begin
                r_data <= io_bus.req_data;
                r_dir  <= io_bus.req_dir;
            end
            if (r_state == StCapture) begin
                r_rsp_data <= io_bus.sr_data_out;
                r_rsp_err  <= (io_bus.sr_data_out != r_model);
            end
        end
    end

    // Register pins decode from state only, so reset drops sr_enable immediately.
    always_comb begin
        io_bus.sr_enable          = 1'b0;
        io_bus.sr_shift_direction = CODE_LOAD;
        io_bus.sr_data_in         = 8'h00;
        unique case (r_state)
            StLoad: begin
                io_bus.sr_enable  = 1'b1;
                io_bus.sr_data_in = r_data;
            end
            StShift: begin
                io_bus.sr_enable          = 1'b1;
                io_bus.sr_shift_direction = r_dir ? CODE_SHL : CODE_SHR;
            end
            default: begin
            end
        endcase
    end

    assign io_bus.req_ready = (r_state == StIdle);
    assign io_bus.rsp_valid = (r_state == StResp);
    assign io_bus.rsp_data  = r_rsp_data;
    assign io_bus.rsp_err   = r_rsp_err;
    assign io_bus.busy      = (r_state != StIdle);

endmodule
